// File: rtl/sha3_scan_dispatcher.sv
// rtl/sha3_scan_dispatcher.sv - scan-job sequencer feeding nonce slots to sha3_iterating_pipe6 and checking its results
//
// Issues nonce slots into the pipe in whole bursts, remembers each slot in an
// in-order tag ring, and pairs every result the pipe returns with its tag.
// A result whose digest word is at or below the job target is a hit.
module sha3_scan_dispatcher #(
  parameter int BURST_LEN = 15,
  parameter int TAG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base_nonce,
  input  logic [31:0] nonce_count,
  input  logic [63:0] target,
  input  logic        pipe_gimme,
  output logic        pipe_sample,
  output logic [63:0] pipe_nonce,
  input  logic        pipe_ogood,
  input  logic [63:0] pipe_word,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [63:0] found_nonce,
  output logic [63:0] found_word,
  output logic [31:0] scanned,
  output logic        tag_underflow
);

  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [AW:0] OCC_ZERO = '0;
  localparam logic [AW:0] OCC_ONE  = {{AW{1'b0}}, 1'b1};

  // The ring must hold one full burst and wrap on a power-of-two index.
  generate
    if ((TAG_DEPTH < BURST_LEN) || ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("TAG_DEPTH must be a power of two and at least BURST_LEN");
    end
  endgenerate

  logic [1:0]    state;
  logic [63:0]   next_nonce;
  logic [31:0]   remaining;
  logic [63:0]   target_q;
  logic          mid_burst;

  // Tag ring: bit 64 marks a real nonce, bits 63:0 hold the nonce.
  logic [64:0]   tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  logic          push;
  logic          slot_valid;
  logic          ring_empty;
  logic          pop_ok;
  logic          head_valid;
  logic [63:0]   head_nonce;
  logic          start_ok;

  // Once a burst has begun every gimme slot is filled, padding if the job ran out.
  assign pipe_sample = (state == ST_FEED) & pipe_gimme & ((remaining != 32'd0) | mid_burst);
  assign push        = pipe_sample;
  assign slot_valid  = (remaining != 32'd0);
  assign ring_empty  = (occ == OCC_ZERO);
  assign pop_ok      = pipe_ogood & ~ring_empty;
  assign head_valid  = tag_mem[rd_ptr][64];
  assign head_nonce  = tag_mem[rd_ptr][63:0];
  assign start_ok    = start & (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign pipe_nonce  = next_nonce;

  // Job control: latch the job, advance the nonce cursor, finish once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      next_nonce <= 64'd0;
      remaining  <= 32'd0;
      target_q   <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state      <= ST_FEED;
            next_nonce <= base_nonce;
            remaining  <= nonce_count;
            target_q   <= target;
          end
        end
        ST_FEED: begin
          if (push && slot_valid) begin
            next_nonce <= next_nonce + 64'd1;
            remaining  <= remaining - 32'd1;
          end
          if (!slot_valid && !mid_burst && !pipe_gimme) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave in the cycle the final pop empties the ring, so done lands right after it.
          if (ring_empty || ((occ == OCC_ONE) && pop_ok)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Burst tracking: a burst stays open until the pipe drops gimme.
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_burst <= 1'b0;
    end else if (!pipe_gimme) begin
      mid_burst <= 1'b0;
    end else if (push) begin
      mid_burst <= 1'b1;
    end
  end

  // Tag storage: record each issued slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= {slot_valid, next_nonce};
    end
  end

  // Ring pointers and occupancy; a pop on an empty ring is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Result checking: count real results, latch hits, flag orphan results.
  always_ff @(posedge clk) begin
    if (rst) begin
      scanned       <= 32'd0;
      found         <= 1'b0;
      found_nonce   <= 64'd0;
      found_word    <= 64'd0;
      tag_underflow <= 1'b0;
    end else begin
      found <= 1'b0;
      if (start_ok) begin
        scanned <= 32'd0;
      end
      if (pipe_ogood && ring_empty) begin
        tag_underflow <= 1'b1;
      end
      if (pop_ok && head_valid) begin
        scanned <= scanned + 32'd1;
        if (pipe_word <= target_q) begin
          found       <= 1'b1;
          found_nonce <= head_nonce;
          found_word  <= pipe_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// tb/tb_sha3_scan_dispatcher.sv - self-checking bench for sha3_scan_dispatcher with a behavioural burst pipe
module tb_sha3_scan_dispatcher;

  localparam int BURST_LEN = 15;
  localparam int TAG_DEPTH = 16;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIXK = 64'h9E37_79B9_7F4A_7C15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_nonce = 64'd0;
  logic [31:0] nonce_count = 32'd0;
  logic [63:0] target = 64'd0;
  logic        pipe_gimme = 1'b0;
  logic        pipe_sample;
  logic [63:0] pipe_nonce;
  logic        pipe_ogood = 1'b0;
  logic [63:0] pipe_word = 64'd0;
  logic        busy;
  logic        done;
  logic        found;
  logic [63:0] found_nonce;
  logic [63:0] found_word;
  logic [31:0] scanned;
  logic        tag_underflow;

  sha3_scan_dispatcher #(
    .BURST_LEN(BURST_LEN),
    .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_nonce   (base_nonce),
    .nonce_count  (nonce_count),
    .target       (target),
    .pipe_gimme   (pipe_gimme),
    .pipe_sample  (pipe_sample),
    .pipe_nonce   (pipe_nonce),
    .pipe_ogood   (pipe_ogood),
    .pipe_word    (pipe_word),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .found_nonce  (found_nonce),
    .found_word   (found_word),
    .scanned      (scanned),
    .tag_underflow(tag_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // Digest word the pipe model returns for a nonce.
  int          word_mode = 0;
  logic [63:0] salt = 64'd0;
  bit          pipe_en = 1'b0;

  function automatic logic [63:0] word_fn(input logic [63:0] n);
    case (word_mode)
      0:       return 64'd0;
      1:       return (n == 64'h107) ? 64'd5 : ALL1;
      default: return (n * MIXK) ^ salt;
    endcase
  endfunction

  // Behavioural pipe: gimme for one burst, wait, return one result per sampled slot.
  int          ph = 0;
  int          pcnt = 0;
  int          spur_req = 0;
  int          spur_done = 0;
  logic [63:0] burst_q[$];
  logic [63:0] job_samples[$];

  initial begin : pipe_model
    forever begin
      @(negedge clk);
      if (pipe_sample) begin
        burst_q.push_back(pipe_nonce);
        job_samples.push_back(pipe_nonce);
      end
      @(posedge clk);
      #1;
      pipe_ogood = 1'b0;
      if (rst) begin
        ph = 0;
        pcnt = 0;
        burst_q.delete();
        pipe_gimme = 1'b0;
      end else if (spur_done != spur_req) begin
        pipe_ogood = 1'b1;
        pipe_word = 64'd0;
        spur_done++;
      end else begin
        case (ph)
          0: begin
            pipe_gimme = 1'b0;
            if (pcnt > 0) pcnt--;
            else if (pipe_en && busy) begin
              ph = 1;
              pcnt = BURST_LEN;
              pipe_gimme = 1'b1;
            end
          end
          1: begin
            pcnt--;
            if (pcnt == 0) begin
              pipe_gimme = 1'b0;
              ph = 2;
              pcnt = $urandom_range(1, 4);
            end
          end
          2: begin
            pcnt--;
            if (pcnt == 0) ph = 3;
          end
          default: begin
            if (burst_q.size() > 0) begin
              pipe_ogood = 1'b1;
              pipe_word = word_fn(burst_q.pop_front());
            end else begin
              ph = 0;
              pcnt = $urandom_range(0, 3);
            end
          end
        endcase
      end
    end
  end

  // Output monitor: log hits and completions, check hit latency and busy/done overlap.
  logic [63:0] found_n_q[$];
  logic [63:0] found_w_q[$];
  int          done_cnt = 0;
  bit          prev_ogood = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (found) begin
        found_n_q.push_back(found_nonce);
        found_w_q.push_back(found_word);
        n_cmp++;
        if (!prev_ogood) begin
          n_bad++;
          $display("FAIL found_latency: pipe_ogood in previous cycle was 0, want 1");
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_with_done", busy, 0);
      end
      prev_ogood = pipe_ogood;
    end
  end

  task automatic wait_pipe_idle();
    int k = 0;
    while (ph != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
  endtask

  task automatic run_job(input string tag, input logic [63:0] b, input logic [31:0] c,
                         input logic [63:0] t, input int mode, input int exp_hits,
                         input int exp_samples);
    logic [63:0] en_q[$];
    logic [63:0] ew_q[$];
    logic [63:0] n;
    logic [63:0] w;
    logic [63:0] slot;
    int cyc;
    word_mode = mode;
    for (longint i = 0; i < longint'(c); i++) begin
      n = b + 64'(i);
      w = word_fn(n);
      if (w <= t) begin
        en_q.push_back(n);
        ew_q.push_back(w);
      end
    end
    wait_pipe_idle();
    job_samples.delete();
    found_n_q.delete();
    found_w_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #2;
    base_nonce = b;
    nonce_count = c;
    target = t;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    n_cmp++;
    if (done_cnt == 0) begin
      n_bad++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, cyc);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, " scanned"}, scanned, c);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " tag_underflow"}, tag_underflow, 0);
    if (exp_hits >= 0) chk({tag, " hits_vs_table"}, found_n_q.size(), exp_hits);
    chk({tag, " hits_vs_model"}, found_n_q.size(), en_q.size());
    for (int i = 0; i < en_q.size() && i < found_n_q.size(); i++) begin
      chk($sformatf("%s found_nonce[%0d]", tag, i), found_n_q[i], en_q[i]);
      chk($sformatf("%s found_word[%0d]", tag, i), found_w_q[i], ew_q[i]);
    end
    chk({tag, " slots"}, job_samples.size(), exp_samples);
    for (int i = 0; i < job_samples.size() && i < exp_samples; i++) begin
      slot = (i < int'(c)) ? b + 64'(i) : b + 64'(c);
      chk($sformatf("%s slot_nonce[%0d]", tag, i), job_samples[i], slot);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] base;
    logic [31:0] count;
    logic [63:0] tgt;
    int          mode;
    int          exp_hits;
    int          exp_samples;
  } job_vec_t;

  job_vec_t vecs[5];

  initial begin : main
    int k;
    logic [31:0] rc;
    vecs[0] = '{"short_pad", 64'h100, 32'd3, ALL1, 0, 3, 15};
    vecs[1] = '{"three_bursts", 64'h200, 32'd40, ALL1, 0, 40, 45};
    vecs[2] = '{"single_hit", 64'h100, 32'd16, 64'd5, 1, 1, 30};
    vecs[3] = '{"no_hit", 64'h100, 32'd16, 64'd4, 1, 0, 30};
    vecs[4] = '{"wrap", 64'hFFFF_FFFF_FFFF_FFFE, 32'd4, ALL1, 0, 4, 15};

    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst pipe_sample", pipe_sample, 0);
    chk("rst pipe_nonce", pipe_nonce, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst found", found, 0);
    chk("rst found_nonce", found_nonce, 0);
    chk("rst found_word", found_word, 0);
    chk("rst scanned", scanned, 0);
    chk("rst tag_underflow", tag_underflow, 0);

    // Zero-length job with gimme low: FEED, DRAIN, then done; a start while busy is ignored.
    @(posedge clk);
    #2;
    base_nonce = 64'h55;
    nonce_count = 32'd0;
    target = ALL1;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(negedge clk);
    chk("zero c1 done", done, 0);
    chk("zero c1 busy", busy, 1);
    chk("zero c1 pipe_nonce", pipe_nonce, 64'h55);
    base_nonce = 64'h99;
    nonce_count = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero c2 done", done, 0);
    chk("zero c2 busy", busy, 1);
    @(negedge clk);
    chk("zero c3 done", done, 1);
    chk("zero c3 busy", busy, 0);
    @(negedge clk);
    chk("ignored_start busy", busy, 0);
    chk("ignored_start pipe_nonce", pipe_nonce, 64'h55);
    chk("zero scanned", scanned, 0);

    pipe_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].name, vecs[v].base, vecs[v].count, vecs[v].tgt,
              vecs[v].mode, vecs[v].exp_hits, vecs[v].exp_samples);
    end

    for (int r = 0; r < 6; r++) begin
      salt = {$urandom, $urandom};
      rc = $urandom_range(1, 50);
      run_job($sformatf("rand%0d", r), {$urandom, $urandom}, rc, {$urandom, $urandom},
              2, -1, int'((rc + 32'd14) / 32'd15) * BURST_LEN);
    end

    // Reset in the middle of a 40-nonce job.
    word_mode = 0;
    wait_pipe_idle();
    job_samples.delete();
    @(posedge clk);
    #2;
    base_nonce = 64'h1000;
    nonce_count = 32'd40;
    target = ALL1;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    k = 0;
    while (job_samples.size() < 20 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("midrst reached_slot20", (job_samples.size() >= 20) ? 1 : 0, 1);
    chk("midrst found_before", (found_nonce != 64'd0) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst scanned", scanned, 0);
    chk("midrst pipe_sample", pipe_sample, 0);
    chk("midrst pipe_nonce", pipe_nonce, 0);
    chk("midrst found_nonce", found_nonce, 0);
    chk("midrst found_word", found_word, 0);
    chk("midrst tag_underflow", tag_underflow, 0);

    run_job("after_rst", 64'h2000, 32'd2, ALL1, 0, 2, 15);

    // Orphan result with the ring empty.
    wait_pipe_idle();
    spur_req++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("spurious tag_underflow", tag_underflow, 1);
    chk("spurious scanned", scanned, 2);
    chk("spurious busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha3_scan_dispatcher.md
# sha3_scan_dispatcher

Job sequencer for `sha3_iterating_pipe6`: accepts a scan job (base nonce, count, target), feeds nonce slots into the pipe in the bursts it demands, and tags every slot in an in-order ring. It pairs the pipe's result bursts with those tags, compares the selected digest word against the target, and reports hits and completion. It sits between the AXI-side job registers and the pipe plus the external matrix-builder that inserts `pipe_nonce` into the hashed state.

## Interface
Parameters:
- `BURST_LEN`, 15, slots per pipe burst; must equal the pipe's burst length.
- `TAG_DEPTH`, 16, tag ring entries; power of two, ≥ `BURST_LEN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job start pulse; ignored unless `busy`=0.
- `base_nonce` in 64: first nonce, sampled on accepted `start`.
- `nonce_count` in 32: nonces to scan, sampled on accepted `start`.
- `target` in 64: hit threshold, sampled on accepted `start`.
- `pipe_gimme` in 1: pipe's `gimme`.
- `pipe_sample` out 1: pipe's `sample`.
- `pipe_nonce` out 64: nonce for the current slot.
- `pipe_ogood` in 1: pipe's `ogood`.
- `pipe_word` in 64: selected digest word, valid with `pipe_ogood`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `found` out 1: one-cycle hit pulse.
- `found_nonce` out 64: nonce of the last hit.
- `found_word` out 64: digest word of the last hit.
- `scanned` out 32: valid results checked in the current or last job.
- `tag_underflow` out 1: sticky error flag.

## Operation
- States:
  - IDLE: `start` → FEED; latch inputs; `next_nonce`=`base_nonce`; `remaining`=`nonce_count`; `scanned`=0.
  - FEED: once `remaining`=0, `mid_burst`=0 and `pipe_gimme`=0 → DRAIN.
  - DRAIN: ring empty → IDLE with `done` pulse.
- `nonce_count`=0 passes through FEED to DRAIN to IDLE with no slot issued; `done` arrives 3 cycles after `start`.
- `pipe_sample` is combinational: (state==FEED) & `pipe_gimme` & (`remaining`≠0 | `mid_burst`).
- A slot is accepted on each clock edge where `pipe_sample`=1.
- `mid_burst` is set on an accepted slot and cleared on any cycle where `pipe_gimme`=0. Once a burst starts, every slot is filled until the pipe drops `gimme`.
- On an accepted slot:
  - Push tag {valid=(`remaining`≠0), nonce=`next_nonce`}.
  - If valid, `next_nonce`+1 (mod 2^64, wraps silently) and `remaining`−1.
  - A padding slot (valid=0) leaves the counters unchanged.
- `pipe_nonce` = `next_nonce` (registered).
- On `pipe_ogood`=1, pop one tag in FIFO order. If the tag is valid:
  - `scanned`+1.
  - If `pipe_word` ≤ `target` (unsigned): latch `found_nonce` and `found_word`, and pulse `found`.
- Pop with an empty ring: set `tag_underflow`; no other effect. Push and pop in the same cycle are legal; occupancy is unchanged.
- A push into a full ring is impossible by construction (one burst in flight, `TAG_DEPTH` ≥ `BURST_LEN`) and is unchecked.
- `start` while `busy`=1 is ignored.
- Reset mid-job:
  - Return to IDLE and empty the ring.
  - Clear `mid_burst`, `scanned`, `found_nonce`, `found_word` and `tag_underflow`.
  - The pipe must be reset by the same `rst` tree.

## Timing
- Reset values: `pipe_sample`=0 (IDLE), `pipe_nonce`=0, `busy`=0, `done`=0, `found`=0, `found_nonce`=0, `found_word`=0, `scanned`=0, `tag_underflow`=0.
- `busy` goes high the cycle after an accepted `start`. It falls in the same cycle `done` is high.
- First `pipe_sample` can be high the cycle after `start` if `pipe_gimme`=1.
- `found`, `found_nonce`, `found_word` and `scanned` update 1 cycle after the `pipe_ogood` cycle.
- `done` is asserted 1 cycle after the last pop, when that pop empties the ring in DRAIN.
- Back-to-back hits give consecutive `found` pulses. The latched values always belong to the most recent hit.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values; `pipe_sample`=0.
- `base_nonce`=0x100, `nonce_count`=3, `BURST_LEN`=15, behavioural pipe model → `pipe_nonce` sequence 0x100, 0x101, 0x102, then 12 padding slots; `scanned`=3; `done` pulses exactly once.
- `nonce_count`=40, `target`=0xFFFF_FFFF_FFFF_FFFF → 3 bursts (45 slots, 5 padding); 40 `found` pulses with `found_nonce` in strict order; `scanned`=40.
- Model returns `pipe_word`=5 only for nonce 0x107, `target`=5 → single `found`, `found_nonce`=0x107, `found_word`=5. Repeat with `target`=4 → no `found`.
- `base_nonce`=0xFFFF_FFFF_FFFF_FFFE, `nonce_count`=4 → nonces …FE, …FF, 0x0, 0x1.
- Assert `rst` mid-burst on nonce 20 of 40 → next cycle IDLE, `busy`=0, `scanned`=0. A new `start` with `nonce_count`=2 completes normally. A spurious `pipe_ogood` on an empty ring sets `tag_underflow`.
